// File: rtl/neuron_mac_if.sv
// Streaming sample input and result output of the neuron MAC.
// The slave side is the MAC itself; the master side feeds samples and collects results.
interface neuron_mac_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_axis_tvalid;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  m_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tdata
    );

    modport master (
        output s_axis_tvalid,
        output s_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tdata
    );
endinterface

// File: rtl/neuron_mac.sv
// Fixed-point neuron pre-activation: two-stage multiply/accumulate over NUM_INPUTS beats,
// plus bias, with output saturation and a sticky saturation flag.
module neuron_mac #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int NUM_INPUTS  = 4,
    localparam int ADDR_WIDTH = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         w_wr_en,
    input  logic [ADDR_WIDTH-1:0]        w_wr_addr,
    input  logic signed [DATA_WIDTH-1:0] w_wr_data,
    input  logic signed [DATA_WIDTH-1:0] bias,
    neuron_mac_if.slave                  axis,
    output logic                         sat_flag
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (DATA_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    logic signed [DATA_WIDTH-1:0] weight [NUM_INPUTS];
    logic [ADDR_WIDTH-1:0]        cnt;
    logic                         cnt_last;
    logic signed [PW-1:0]         prod;
    logic                         prod_valid;
    logic                         prod_last;
    logic signed [PW-1:0]         acc;
    logic signed [PW-1:0]         shifted;
    logic signed [PW-1:0]         acc_next;
    logic signed [PW-1:0]         total;
    logic [DATA_WIDTH-1:0]        sat_val;
    logic                         sat_hit;

    assign cnt_last = (cnt == ADDR_WIDTH'(NUM_INPUTS - 1));

    // A write landing on the index being read this cycle takes effect only after the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                weight[i] <= '0;
            end
        end else if (w_wr_en && (int'(w_wr_addr) < NUM_INPUTS)) begin
            weight[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt        <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            prod_last  <= 1'b0;
        end else begin
            prod_valid <= axis.s_axis_tvalid;
            prod_last  <= axis.s_axis_tvalid && cnt_last;
            if (axis.s_axis_tvalid) begin
                prod <= PW'($signed(axis.s_axis_tdata)) * PW'(weight[cnt]);
                cnt  <= cnt_last ? '0 : cnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        shifted  = prod >>> FRAC_BITS;
        acc_next = acc + shifted;
        total    = acc_next + PW'(bias);
        sat_hit  = 1'b0;
        sat_val  = total[DATA_WIDTH-1:0];
        if (total > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (total < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    // The last product closes the vector and restarts acc from 0 on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc                <= '0;
            axis.m_axis_tvalid <= 1'b0;
            axis.m_axis_tdata  <= '0;
            sat_flag           <= 1'b0;
        end else begin
            axis.m_axis_tvalid <= prod_valid && prod_last;
            if (prod_valid) begin
                if (prod_last) begin
                    acc               <= '0;
                    axis.m_axis_tdata <= sat_val;
                    if (sat_hit) begin
                        sat_flag <= 1'b1;
                    end
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac at Q16.16, four inputs per vector.
module tb_neuron_mac;
    logic        clk;
    logic        reset_n;
    logic        w_wr_en;
    logic [1:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [31:0] bias;
    logic        sat_flag;
    int          total;
    int          bad;

    neuron_mac_if #(.DATA_WIDTH(32)) axis ();

    neuron_mac #(
        .DATA_WIDTH(32),
        .FRAC_BITS (16),
        .NUM_INPUTS(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .w_wr_en  (w_wr_en),
        .w_wr_addr(w_wr_addr),
        .w_wr_data(w_wr_data),
        .bias     (bias),
        .axis     (axis),
        .sat_flag (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        w_wr_en   = 1'b1;
        w_wr_addr = a;
        w_wr_data = d;
        @(posedge clk);
        #1 w_wr_en = 1'b0;
    endtask

    task automatic load_all(input logic [31:0] d);
        for (int i = 0; i < 4; i++) wr(2'(i), d);
    endtask

    task automatic beat(input logic [31:0] d);
        @(negedge clk);
        axis.s_axis_tvalid = 1'b1;
        axis.s_axis_tdata  = d;
        @(posedge clk);
        #1 axis.s_axis_tvalid = 1'b0;
    endtask

    // Last beat in cycle n: strobe visible only in cycle n+2, then data holds.
    task automatic expect_strobe(input string tag, input logic [31:0] exp);
        @(negedge clk);
        chk({tag, "_early"}, 64'(axis.m_axis_tvalid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(axis.m_axis_tvalid), 64'd1);
        chk({tag, "_data"}, 64'(axis.m_axis_tdata), 64'(exp));
        @(negedge clk);
        chk({tag, "_one_cycle"}, 64'(axis.m_axis_tvalid), 64'd0);
        chk({tag, "_hold"}, 64'(axis.m_axis_tdata), 64'(exp));
    endtask

    task automatic run_vec(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] v3, input int gap, input logic [31:0] exp,
                           input string tag);
        logic [31:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int i = 0; i < 4; i++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
            beat(v[i]);
        end
        expect_strobe(tag, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        w_wr_en = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        bias = '0;
        axis.s_axis_tvalid = 1'b0;
        axis.s_axis_tdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(axis.m_axis_tvalid), 64'd0);
        chk("rst_data", 64'(axis.m_axis_tdata), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        reset_n = 1'b1;

        load_all(32'h0001_0000);
        run_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 0,
                32'h000A_0000, "contig");
        chk("contig_sat", 64'(sat_flag), 64'd0);

        run_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 3,
                32'h000A_0000, "gaps");

        // Back-to-back vectors: beat k driven at negedge k, strobes seen at negedges 5 and 9.
        bias = 32'h0000_8000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_valid_%0d", k), 64'(axis.m_axis_tvalid),
                64'((k == 5) || (k == 9)));
            if (k == 5) chk("b2b_first", 64'(axis.m_axis_tdata), 64'h0000_0000_000A_8000);
            if (k == 9) chk("b2b_second", 64'(axis.m_axis_tdata), 64'h0000_0000_FFFC_8000);
            if (k < 4) begin
                axis.s_axis_tvalid = 1'b1;
                axis.s_axis_tdata  = 32'((k + 1) << 16);
            end else if (k < 8) begin
                axis.s_axis_tvalid = 1'b1;
                axis.s_axis_tdata  = 32'hFFFF_0000;
            end else begin
                axis.s_axis_tvalid = 1'b0;
            end
        end
        bias = '0;

        // Weight 2 rewritten in the same cycle beat 2 reads it.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            axis.s_axis_tvalid = 1'b1;
            axis.s_axis_tdata  = 32'((i + 1) << 16);
            w_wr_en   = (i == 2);
            w_wr_addr = 2'd2;
            w_wr_data = 32'h0002_0000;
        end
        @(posedge clk);
        #1;
        axis.s_axis_tvalid = 1'b0;
        w_wr_en = 1'b0;
        expect_strobe("wr_same_cycle", 32'h000A_0000);
        run_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 0,
                32'h000D_0000, "wr_next_vec");

        load_all(32'h7FFF_0000);
        run_vec(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 0,
                32'h7FFF_FFFF, "sat_pos");
        chk("sat_set", 64'(sat_flag), 64'd1);
        load_all(32'h0001_0000);
        run_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1,
                32'h000A_0000, "after_sat");
        chk("sat_sticky", 64'(sat_flag), 64'd1);

        // Reset mid-vector: partial sum and weights are discarded.
        beat(32'h0001_0000);
        beat(32'h0002_0000);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(axis.m_axis_tvalid), 64'd0);
        chk("midrst_data", 64'(axis.m_axis_tdata), 64'd0);
        chk("midrst_sat", 64'(sat_flag), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_strobe", 64'(axis.m_axis_tvalid), 64'd0);
        end
        run_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 0,
                32'h0000_0000, "zero_weights");
        load_all(32'h0001_0000);
        run_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 0,
                32'h000A_0000, "reloaded");
        chk("reloaded_sat", 64'(sat_flag), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
